// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Each operation is granted, held for the ALU latency, then captured and returned with a done pulse.
module alu_arbiter #(
    parameter int WIDTH   = 4,
    parameter int OPW     = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             gnt_id,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_instr,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPT
    } state_t;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic             last, last_n;
    logic             pick;
    logic             done0_n, done1_n, busy_n, gnt_n;
    logic [WIDTH-1:0] result_n, alu_a_n, alu_b_n;
    logic [OPW-1:0]   alu_instr_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            done0     <= 1'b0;
            done1     <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            gnt_id    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_instr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            done0     <= done0_n;
            done1     <= done1_n;
            result    <= result_n;
            busy      <= busy_n;
            gnt_id    <= gnt_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_instr <= alu_instr_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_n      = last;
        done0_n     = 1'b0;
        done1_n     = 1'b0;
        result_n    = result;
        busy_n      = busy;
        gnt_n       = gnt_id;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        alu_instr_n = alu_instr;
        // Contention goes to whoever was not served last; a lone request wins outright.
        pick        = (req0 && req1) ? ~last : req1;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_n       = pick;
                    last_n      = pick;
                    busy_n      = 1'b1;
                    alu_a_n     = pick ? a1 : a0;
                    alu_b_n     = pick ? b1 : b0;
                    alu_instr_n = pick ? op1 : op0;
                    cnt_n       = 3'(ALU_LAT - 1);
                    state_n     = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = CAPT;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            CAPT: begin
                result_n = alu_out;
                done0_n  = ~gnt_id;
                done1_n  = gnt_id;
                busy_n   = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU_LAT=1 and ALU_LAT=3 instances driven in parallel, each with a stub ALU,
// checked every cycle against a transaction-timing reference model plus directed timing checks.
module tb_alu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req0, req1;
    logic [3:0] a0, b0, op0, a1, b1, op1;

    logic       done0_w [2];
    logic       done1_w [2];
    logic       busy_w  [2];
    logic       gnt_w   [2];
    logic [3:0] res_w   [2];
    logic [3:0] aa_w    [2];
    logic [3:0] ab_w    [2];
    logic [3:0] ai_w    [2];
    logic [3:0] ao_w    [2];

    alu_arbiter #(.WIDTH(4), .OPW(4), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .done0(done0_w[0]), .done1(done1_w[0]), .result(res_w[0]),
        .busy(busy_w[0]), .gnt_id(gnt_w[0]),
        .alu_a(aa_w[0]), .alu_b(ab_w[0]), .alu_instr(ai_w[0]),
        .alu_out(ao_w[0])
    );

    alu_arbiter #(.WIDTH(4), .OPW(4), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .done0(done0_w[1]), .done1(done1_w[1]), .result(res_w[1]),
        .busy(busy_w[1]), .gnt_id(gnt_w[1]),
        .alu_a(aa_w[1]), .alu_b(ab_w[1]), .alu_instr(ai_w[1]),
        .alu_out(ao_w[1])
    );

    // Stub registered ALUs: op 1 subtracts, anything else adds.
    function automatic logic [3:0] stub_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        return (op == 4'h1) ? a - b : a + b;
    endfunction

    logic [3:0] s1;
    logic [3:0] s3 [3];
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s3[0] <= '0;
            s3[1] <= '0;
            s3[2] <= '0;
        end else begin
            s1    <= stub_f(ai_w[0], aa_w[0], ab_w[0]);
            s3[0] <= stub_f(ai_w[1], aa_w[1], ab_w[1]);
            s3[1] <= s3[0];
            s3[2] <= s3[1];
        end
    end
    assign ao_w[0] = s1;
    assign ao_w[1] = s3[2];

    function automatic logic [3:0] ref_op(input int op, input int a, input int b);
        int r;
        r = (op == 1) ? (a - b + 16) : (a + b);
        return 4'(r % 16);
    endfunction

    // Reference model: an operation granted at edge n is captured at edge n+LAT+1.
    int         lat [2] = '{1, 3};
    int         edge_n = 0;
    bit         m_fl   [2];
    bit         m_last [2];
    bit         m_id   [2];
    int         m_cap  [2];
    logic [3:0] m_pend [2];
    logic       e_d0   [2];
    logic       e_d1   [2];
    logic       e_busy [2];
    logic       e_gnt  [2];
    logic [3:0] e_res  [2];
    logic [3:0] e_a    [2];
    logic [3:0] e_b    [2];
    logic [3:0] e_op   [2];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int i);
        bit id;
        if (rst) begin
            m_fl[i] = 1'b0; m_last[i] = 1'b1;
            e_d0[i] = 1'b0; e_d1[i] = 1'b0; e_busy[i] = 1'b0; e_gnt[i] = 1'b0;
            e_res[i] = '0; e_a[i] = '0; e_b[i] = '0; e_op[i] = '0;
        end else if (m_fl[i]) begin
            if (edge_n == m_cap[i]) begin
                e_res[i]  = m_pend[i];
                e_d0[i]   = !m_id[i];
                e_d1[i]   = m_id[i];
                e_busy[i] = 1'b0;
                m_fl[i]   = 1'b0;
            end
        end else begin
            e_d0[i] = 1'b0;
            e_d1[i] = 1'b0;
            if (req0 || req1) begin
                id        = (req0 && req1) ? !m_last[i] : req1;
                m_id[i]   = id;
                m_last[i] = id;
                m_fl[i]   = 1'b1;
                m_cap[i]  = edge_n + lat[i] + 1;
                e_gnt[i]  = id;
                e_busy[i] = 1'b1;
                e_a[i]    = id ? a1 : a0;
                e_b[i]    = id ? b1 : b0;
                e_op[i]   = id ? op1 : op0;
                m_pend[i] = ref_op(int'(e_op[i]), int'(e_a[i]), int'(e_b[i]));
            end
        end
    endtask

    task automatic compare(input int i);
        string p;
        p = $sformatf("lat%0d", lat[i]);
        chk({p, ".done0"},  32'(done0_w[i]), 32'(e_d0[i]));
        chk({p, ".done1"},  32'(done1_w[i]), 32'(e_d1[i]));
        chk({p, ".busy"},   32'(busy_w[i]),  32'(e_busy[i]));
        chk({p, ".gnt_id"}, 32'(gnt_w[i]),   32'(e_gnt[i]));
        chk({p, ".result"}, 32'(res_w[i]),   32'(e_res[i]));
        chk({p, ".alu_a"},  32'(aa_w[i]),    32'(e_a[i]));
        chk({p, ".alu_b"},  32'(ab_w[i]),    32'(e_b[i]));
        chk({p, ".alu_in"}, 32'(ai_w[i]),    32'(e_op[i]));
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge(0);
        model_edge(1);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int qid[$];
        int qres[$];
        int qstep[$];
        int cnt;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;

        do_reset();
        chk("reset.busy",   32'(busy_w[0]), 32'd0);
        chk("reset.result", 32'(res_w[0]),  32'd0);
        chk("reset.alu_a",  32'(aa_w[0]),   32'd0);

        // Single request, 7 + A = 1 (mod 16)
        req0 = 1'b1; a0 = 4'h7; b0 = 4'hA; op0 = 4'h0;
        step();
        chk("single.alu_a",  32'(aa_w[0]), 32'h7);
        chk("single.alu_b",  32'(ab_w[0]), 32'hA);
        chk("single.alu_in", 32'(ai_w[0]), 32'h0);
        req0 = 1'b0;
        step();
        chk("single.done_early", 32'(done0_w[0]), 32'd0);
        step();
        chk("single.done0",  32'(done0_w[0]), 32'd1);
        chk("single.result", 32'(res_w[0]),   32'h1);
        chk("single.done1",  32'(done1_w[0]), 32'd0);
        chk("single.gnt",    32'(gnt_w[0]),   32'd0);
        step();
        chk("single.done0_clear", 32'(done0_w[0]), 32'd0);
        repeat (4) step();

        // Simultaneous requests held continuously
        do_reset();
        req0 = 1'b1; a0 = 4'h3; b0 = 4'h2; op0 = 4'h0;
        req1 = 1'b1; a1 = 4'h9; b1 = 4'h4; op1 = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (done0_w[0]) begin qid.push_back(0); qres.push_back(int'(res_w[0])); qstep.push_back(k); end
            if (done1_w[0]) begin qid.push_back(1); qres.push_back(int'(res_w[0])); qstep.push_back(k); end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) step();
        chk("simul.count", 32'(qid.size()), 32'd4);
        for (int j = 0; j < qid.size() && j < 4; j++) begin
            chk($sformatf("simul.id%0d", j),   32'(qid[j]),   32'(j % 2));
            chk($sformatf("simul.res%0d", j),  32'(qres[j]),  32'd5);
            chk($sformatf("simul.step%0d", j), 32'(qstep[j]), 32'(3 * (j + 1)));
        end

        // Lone requester back-to-back, 5 - 1 = 4
        do_reset();
        req1 = 1'b1; a1 = 4'h5; b1 = 4'h1; op1 = 4'h1;
        cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (done1_w[0]) cnt++;
            chk($sformatf("lone.gnt%0d", k), 32'(gnt_w[0]), 32'd1);
            if (k % 3 == 0) chk($sformatf("lone.done%0d", k), 32'(done1_w[0]), 32'd1);
        end
        req1 = 1'b0;
        repeat (4) begin
            step();
            if (done1_w[0]) cnt++;
        end
        chk("lone.count", 32'(cnt), 32'd3);

        // Request dropped and operand changed after grant, 2 - 3 = F
        do_reset();
        req0 = 1'b1; a0 = 4'h2; b0 = 4'h3; op0 = 4'h1;
        step();
        req0 = 1'b0; a0 = 4'hF;
        cnt = 0;
        repeat (6) begin
            step();
            if (done0_w[0]) begin
                cnt++;
                chk("drop.result", 32'(res_w[0]), 32'hF);
            end
        end
        chk("drop.count", 32'(cnt), 32'd1);
        chk("drop.busy",  32'(busy_w[0]), 32'd0);

        // Reset while waiting on the ALU
        do_reset();
        req0 = 1'b1; a0 = 4'h4; b0 = 4'h4; op0 = 4'h0;
        step();
        rst = 1'b1;
        step();
        chk("midrst.done0", 32'(done0_w[0]), 32'd0);
        chk("midrst.busy",  32'(busy_w[0]),  32'd0);
        chk("midrst.alu_a", 32'(aa_w[0]),    32'd0);
        chk("midrst.gnt",   32'(gnt_w[0]),   32'd0);
        rst = 1'b0;
        step();
        chk("midrst.regrant_busy", 32'(busy_w[0]), 32'd1);
        chk("midrst.regrant_a",    32'(aa_w[0]),   32'h4);
        req0 = 1'b0;
        step();
        step();
        chk("midrst.done0_after", 32'(done0_w[0]), 32'd1);
        chk("midrst.result",      32'(res_w[0]),   32'h8);
        repeat (4) step();

        // ALU_LAT=3 instance, 6 + 7 = D
        do_reset();
        req1 = 1'b1; a1 = 4'h6; b1 = 4'h7; op1 = 4'h0;
        step();
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lat3.busy_e%0d", k),  32'(busy_w[1]),  32'd1);
            chk($sformatf("lat3.alu_a_e%0d", k), 32'(aa_w[1]),    32'h6);
            chk($sformatf("lat3.alu_b_e%0d", k), 32'(ab_w[1]),    32'h7);
            chk($sformatf("lat3.done_e%0d", k),  32'(done1_w[1]), 32'd0);
            step();
        end
        chk("lat3.done1",  32'(done1_w[1]), 32'd1);
        chk("lat3.result", 32'(res_w[1]),   32'hD);
        chk("lat3.alu_a4", 32'(aa_w[1]),    32'h6);
        chk("lat3.busy4",  32'(busy_w[1]),  32'd0);
        repeat (2) step();

        // Randomized traffic with occasional resets
        do_reset();
        for (int k = 0; k < 300; k++) begin
            rst  = ($urandom_range(0, 49) == 0);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            a0 = 4'($urandom); b0 = 4'($urandom); op0 = 4'($urandom_range(0, 1));
            a1 = 4'($urandom); b1 = 4'($urandom); op1 = 4'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (6) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
